wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports: clk input 1, clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst input 1, reset, synchronous, active-high.
REQ-003 SHALL have write port 1 inputs: we1 (1, write enable), waddr1 (5, register address), wdata1 (32, write data). Port 1 is the older instruction of the commit pair.
REQ-004 SHALL have write port 2 inputs: we2 (1), waddr2 (5), wdata2 (32). Port 2 is the younger instruction of the commit pair.
REQ-005 SHALL have HI/LO write inputs: whilo (1, HI/LO write enable), hi_i (32), lo_i (32).
REQ-006 SHALL have LLbit inputs: llbit_we (1, write enable), llbit_i (1, value), llbit_clr (1, clear request from CP0 on ERET or exception).
REQ-007 SHALL have four read ports, n=1..4: re_n input 1 (read enable), raddr_n input 5 (address), rdata_n output 32 (read data). Ports 1/2 serve issue slot 0; ports 3/4 serve issue slot 1.
REQ-008 SHALL have outputs hi_o (32), lo_o (32) and llbit_o (1).

Function
REQ-009 SHALL hold 32 x 32-bit GPRs; r0 reads 0 always, and writes to address 0 are discarded.
REQ-010 SHALL commit each enabled GPR write at the rising clk edge; write-to-visible latency is 1 cycle.
REQ-011 SHALL, when we1 and we2 target the same nonzero address, store wdata2 only (the younger instruction wins).
REQ-012 SHALL drive each rdata_n combinationally (0-cycle read).
REQ-013 SHALL define rdata_n with this priority:
  - rst=1 -> 0.
  - re_n=0 -> 0.
  - raddr_n=0 -> 0.
  - raddr_n==waddr2 with we2 -> wdata2.
  - raddr_n==waddr1 with we1 -> wdata1.
  - otherwise -> stored value.
REQ-014 SHALL apply the same-cycle write bypass to all four read ports independently and simultaneously.
REQ-015 SHALL update the HI and LO registers together when whilo=1, with no partial write.
REQ-016 SHALL bypass HI/LO: while whilo=1, hi_o/lo_o equal hi_i/lo_i in the same cycle; otherwise they equal the stored values.
REQ-017 SHALL update the LLbit register as follows:
  - llbit_clr=1 -> 0, with priority over llbit_we.
  - else llbit_we=1 -> llbit_i.
  - else hold.
REQ-018 SHALL bypass LLbit: llbit_o = 0 if llbit_clr; else llbit_i if llbit_we; else the stored value.
REQ-019 SHALL leave all state unchanged in a cycle with every enable low.
REQ-020 SHALL not stall or back-pressure; it accepts one commit pair every cycle.

Reset
REQ-021 SHALL clear all 32 GPRs, HI, LO and LLbit to 0 at the first rising edge with rst=1.
REQ-022 SHALL ignore every write input on edges where rst=1, including writes in flight when reset is asserted mid-operation.
REQ-023 SHALL drive rdata_1..4, hi_o, lo_o and llbit_o to 0 while rst=1, with no bypass.
REQ-024 SHALL honour writes starting from the first edge with rst=0.

Verification
REQ-025 Dual write:
  - Stimulus: we1 waddr1=5 wdata1=0x11111111 and we2 waddr2=6 wdata2=0x22222222, one edge, then read addresses 5 and 6.
  - Response: 0x11111111 and 0x22222222.
REQ-026 Write collision:
  - Stimulus: we1 and we2 both to address 7, wdata1=0xAAAA0000, wdata2=0x0000BBBB.
  - Response: same-cycle read of 7 returns 0x0000BBBB; next cycle it also returns 0x0000BBBB.
REQ-027 r0 protection:
  - Stimulus: we1 waddr1=0 wdata1=0xFFFFFFFF, with re1 raddr1=0 in the same cycle and the next.
  - Response: rdata1=0 in both cycles.
REQ-028 Four-port bypass:
  - Stimulus: reg3=0x3 stored; in one cycle we1 to address 3 with 0x33, and all four ports read address 3.
  - Response: all four rdata=0x33 in that cycle.
REQ-029 HI/LO and LLbit:
  - Stimulus: whilo with hi=0x1, lo=0x2; then llbit_we=1 llbit_i=1; then llbit_clr=1 together with llbit_we=1 llbit_i=1.
  - Response: hi_o/lo_o = 1/2 in the same cycle as whilo; llbit_o=1 then 0; stored LLbit=0 afterwards.
REQ-030 Mid-run reset:
  - Stimulus: write 0x55 to address 9, then assert rst for 1 cycle while we1 writes 0x66 to address 9.
  - Response: after reset, address 9 reads 0; hi_o, lo_o and llbit_o read 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Dual-commit 32x32 GPR file with four bypassing read ports, plus HI/LO and LLbit.
// Port 2 carries the younger instruction, so it wins both the bypass and a same-address write.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we1,
  input  logic [4:0]  waddr1,
  input  logic [31:0] wdata1,
  input  logic        we2,
  input  logic [4:0]  waddr2,
  input  logic [31:0] wdata2,
  input  logic        whilo,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        llbit_we,
  input  logic        llbit_i,
  input  logic        llbit_clr,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        re3,
  input  logic [4:0]  raddr3,
  output logic [31:0] rdata3,
  input  logic        re4,
  input  logic [4:0]  raddr4,
  output logic [31:0] rdata4,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        llbit_o
);

  logic [31:0] gpr [32];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        llbit_q;

  logic [3:0]  re_v;
  logic [4:0]  raddr_v [4];
  logic [31:0] rdata_v [4];

  // Port 2 is written last so it overrides port 1 on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      llbit_q <= 1'b0;
    end else begin
      if (we1 && waddr1 != 5'd0) gpr[waddr1] <= wdata1;
      if (we2 && waddr2 != 5'd0) gpr[waddr2] <= wdata2;
      if (whilo) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
      if (llbit_clr)     llbit_q <= 1'b0;
      else if (llbit_we) llbit_q <= llbit_i;
    end
  end

  assign re_v       = {re4, re3, re2, re1};
  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;
  assign raddr_v[2] = raddr3;
  assign raddr_v[3] = raddr4;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      rdata_v[n] = '0;
      if (!rst && re_v[n] && raddr_v[n] != 5'd0) begin
        if (we2 && raddr_v[n] == waddr2)      rdata_v[n] = wdata2;
        else if (we1 && raddr_v[n] == waddr1) rdata_v[n] = wdata1;
        else                                  rdata_v[n] = gpr[raddr_v[n]];
      end
    end
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign rdata3 = rdata_v[2];
  assign rdata4 = rdata_v[3];

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    llbit_o = 1'b0;
    if (!rst) begin
      hi_o    = whilo ? hi_i : hi_q;
      lo_o    = whilo ? lo_i : lo_q;
      llbit_o = llbit_clr ? 1'b0 : (llbit_we ? llbit_i : llbit_q);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table followed by random commits checked
// against a post-commit view of an architectural register model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we1, we2, whilo, llbit_we, llbit_i, llbit_clr;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2, hi_i, lo_i;
  logic        re1, re2, re3, re4;
  logic [4:0]  raddr1, raddr2, raddr3, raddr4;
  logic [31:0] rdata1, rdata2, rdata3, rdata4, hi_o, lo_o;
  logic        llbit_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic             rst;
    logic             we1;
    logic [4:0]       wa1;
    logic [31:0]      wd1;
    logic             we2;
    logic [4:0]       wa2;
    logic [31:0]      wd2;
    logic             whilo;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic             llwe;
    logic             lli;
    logic             llclr;
    logic [3:0]       re;
    logic [3:0][4:0]  ra;
    logic [3:0][31:0] exp_rd;
    logic [31:0]      exp_hi;
    logic [31:0]      exp_lo;
    logic             exp_ll;
  } vec_t;

  // Architectural state as a program would see it.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic        m_ll;

  // Running expectations used while building the directed table.
  logic [31:0] s_hi, s_lo;
  logic        s_ll;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
    .llbit_we(llbit_we), .llbit_i(llbit_i), .llbit_clr(llbit_clr),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .re3(re3), .raddr3(raddr3), .rdata3(rdata3),
    .re4(re4), .raddr4(raddr4), .rdata4(rdata4),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
  );

  // Clock and reset-time defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic drive(input vec_t v);
    rst = v.rst;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    we2 = v.we2; waddr2 = v.wa2; wdata2 = v.wd2;
    whilo = v.whilo; hi_i = v.hi; lo_i = v.lo;
    llbit_we = v.llwe; llbit_i = v.lli; llbit_clr = v.llclr;
    re1 = v.re[0]; re2 = v.re[1]; re3 = v.re[2]; re4 = v.re[3];
    raddr1 = v.ra[0]; raddr2 = v.ra[1]; raddr3 = v.ra[2]; raddr4 = v.ra[3];
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  // One commit cycle. A read sees the register file as it will be after this
  // cycle's commits; reset blanks every output and wipes the model.
  task automatic apply(input vec_t v, input bit use_tbl, input int idx);
    logic [31:0] nx [32];
    logic [31:0] nhi, nlo;
    logic        nll;
    logic [3:0][31:0] e_rd;
    logic [31:0] e_hi, e_lo;
    logic        e_ll;
    drive(v);
    @(negedge clk);
    nx = m_gpr;
    if (v.we1) nx[v.wa1] = v.wd1;
    if (v.we2) nx[v.wa2] = v.wd2;
    nx[0] = '0;
    nhi = v.whilo ? v.hi : m_hi;
    nlo = v.whilo ? v.lo : m_lo;
    nll = v.llclr ? 1'b0 : (v.llwe ? v.lli : m_ll);
    if (use_tbl) begin
      e_rd = v.exp_rd; e_hi = v.exp_hi; e_lo = v.exp_lo; e_ll = v.exp_ll;
    end else begin
      for (int n = 0; n < 4; n++)
        e_rd[n] = (v.rst || !v.re[n]) ? 32'h0 : nx[v.ra[n]];
      e_hi = v.rst ? 32'h0 : nhi;
      e_lo = v.rst ? 32'h0 : nlo;
      e_ll = v.rst ? 1'b0 : nll;
    end
    chk("rdata1", idx, rdata1, e_rd[0]);
    chk("rdata2", idx, rdata2, e_rd[1]);
    chk("rdata3", idx, rdata3, e_rd[2]);
    chk("rdata4", idx, rdata4, e_rd[3]);
    chk("hi_o", idx, hi_o, e_hi);
    chk("lo_o", idx, lo_o, e_lo);
    chk("llbit_o", idx, {31'h0, llbit_o}, {31'h0, e_ll});
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0; m_ll = 1'b0;
    end else begin
      m_gpr = nx; m_hi = nhi; m_lo = nlo; m_ll = nll;
    end
    #1;
  endtask

  function automatic vec_t mk();
    vec_t v;
    v = '0;
    v.re = 4'hf;
    v.exp_hi = s_hi;
    v.exp_lo = s_lo;
    v.exp_ll = s_ll;
    return v;
  endfunction

  function automatic vec_t rd_all(input vec_t v, input logic [4:0] a, input logic [31:0] d);
    vec_t r;
    r = v;
    r.ra = {a, a, a, a};
    r.exp_rd = {d, d, d, d};
    return r;
  endfunction

  // Scoreboard driver: directed table, then random commits.
  initial begin
    vec_t tbl[$];
    vec_t v;
    s_hi = '0; s_lo = '0; s_ll = 1'b0;
    v = mk(); v.rst = 1'b1;
    drive(v);

    // Reset with every write enable active: nothing may leak through.
    v = mk(); v.rst = 1; v.we1 = 1; v.wa1 = 9; v.wd1 = 32'h77;
    v.whilo = 1; v.hi = 32'h5; v.lo = 32'h6; v.llwe = 1; v.lli = 1;
    v = rd_all(v, 9, 0); tbl.push_back(v);
    v = mk(); v.rst = 1; v = rd_all(v, 9, 0); tbl.push_back(v);
    // Dual write to distinct registers.
    v = mk(); v.we1 = 1; v.wa1 = 5; v.wd1 = 32'h11111111;
    v.we2 = 1; v.wa2 = 6; v.wd2 = 32'h22222222;
    v.ra = {5'd6, 5'd5, 5'd6, 5'd5};
    v.exp_rd = {32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111};
    tbl.push_back(v);
    v = mk(); v.ra = {5'd4, 5'd0, 5'd6, 5'd5};
    v.exp_rd = {32'h0, 32'h0, 32'h22222222, 32'h11111111};
    tbl.push_back(v);
    // Same-address collision: younger port wins.
    v = mk(); v.we1 = 1; v.wa1 = 7; v.wd1 = 32'hAAAA0000;
    v.we2 = 1; v.wa2 = 7; v.wd2 = 32'h0000BBBB;
    v = rd_all(v, 7, 32'h0000BBBB); tbl.push_back(v);
    v = mk(); v = rd_all(v, 7, 32'h0000BBBB); tbl.push_back(v);
    // r0 is never written and never bypassed.
    v = mk(); v.we1 = 1; v.wa1 = 0; v.wd1 = 32'hFFFFFFFF; v = rd_all(v, 0, 0); tbl.push_back(v);
    v = mk(); v = rd_all(v, 0, 0); tbl.push_back(v);
    v = mk(); v.re = 4'h0; v = rd_all(v, 5, 0); tbl.push_back(v);
    // Four ports bypass the same write at once.
    v = mk(); v.we1 = 1; v.wa1 = 3; v.wd1 = 32'h3; v = rd_all(v, 3, 32'h3); tbl.push_back(v);
    v = mk(); v.we1 = 1; v.wa1 = 3; v.wd1 = 32'h33; v = rd_all(v, 3, 32'h33); tbl.push_back(v);
    v = mk(); v = rd_all(v, 3, 32'h33); tbl.push_back(v);
    // HI/LO bypass and store, LLbit set then clear-over-write.
    v = mk(); v.whilo = 1; v.hi = 32'h1; v.lo = 32'h2; v.exp_hi = 32'h1; v.exp_lo = 32'h2;
    v = rd_all(v, 5, 32'h11111111); tbl.push_back(v);
    s_hi = 32'h1; s_lo = 32'h2;
    v = mk(); v = rd_all(v, 7, 32'h0000BBBB); tbl.push_back(v);
    v = mk(); v.llwe = 1; v.lli = 1; v.exp_ll = 1; v = rd_all(v, 6, 32'h22222222); tbl.push_back(v);
    s_ll = 1'b1;
    v = mk(); v = rd_all(v, 3, 32'h33); tbl.push_back(v);
    v = mk(); v.llclr = 1; v.llwe = 1; v.lli = 1; v.exp_ll = 0; v = rd_all(v, 3, 32'h33); tbl.push_back(v);
    s_ll = 1'b0;
    v = mk(); v = rd_all(v, 3, 32'h33); tbl.push_back(v);
    // Mid-run reset discards the in-flight write.
    v = mk(); v.we1 = 1; v.wa1 = 9; v.wd1 = 32'h55; v = rd_all(v, 9, 32'h55); tbl.push_back(v);
    v = mk(); v = rd_all(v, 9, 32'h55); tbl.push_back(v);
    v = mk(); v.rst = 1; v.we1 = 1; v.wa1 = 9; v.wd1 = 32'h66;
    v.exp_hi = 0; v.exp_lo = 0; v.exp_ll = 0; v = rd_all(v, 9, 0); tbl.push_back(v);
    s_hi = '0; s_lo = '0; s_ll = 1'b0;
    v = mk(); v = rd_all(v, 9, 0); tbl.push_back(v);
    v = mk(); v.ra = {5'd7, 5'd6, 5'd5, 5'd3}; tbl.push_back(v);
    // First edge after reset is honoured.
    v = mk(); v.we1 = 1; v.wa1 = 9; v.wd1 = 32'h99; v = rd_all(v, 9, 32'h99); tbl.push_back(v);
    v = mk(); v = rd_all(v, 9, 32'h99); tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i], 1'b1, i);

    // Narrow address range keeps collisions and bypass hits frequent.
    for (int k = 0; k < 400; k++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 39) == 0);
      v.we1   = 1'($urandom_range(0, 1));
      v.wa1   = 5'($urandom_range(0, 7));
      v.wd1   = $urandom;
      v.we2   = 1'($urandom_range(0, 1));
      v.wa2   = 5'($urandom_range(0, 7));
      v.wd2   = $urandom;
      v.whilo = ($urandom_range(0, 3) == 0);
      v.hi    = $urandom;
      v.lo    = $urandom;
      v.llwe  = 1'($urandom_range(0, 1));
      v.lli   = 1'($urandom_range(0, 1));
      v.llclr = ($urandom_range(0, 5) == 0);
      v.re    = 4'($urandom_range(0, 15));
      for (int n = 0; n < 4; n++) v.ra[n] = 5'($urandom_range(0, 7));
      apply(v, 1'b0, 100 + k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
